// File: rtl/conv_window_accum_pkg.sv
// Shared definitions for the window accumulator: default data width,
// saturation limits and the FSM state encoding.
package conv_window_accum_pkg;

  localparam int DATA_WIDTH_DEF = 17;

  localparam logic signed [DATA_WIDTH_DEF-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
  localparam logic signed [DATA_WIDTH_DEF-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/conv_window_accum_if.sv
// Product-in / result-out stream bundle of the window accumulator.
// The slave side is the accumulator, the master side is its environment.
interface conv_window_accum_if #(
  parameter int DW = conv_window_accum_pkg::DATA_WIDTH_DEF
);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic signed [DW-1:0] bias;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_sat;

  modport slave (
    input  in_valid, in_data, bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_data, bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/conv_window_accum_sat_add.sv
// Two's-complement adder that clamps to the representable range on overflow
// instead of wrapping; no widening, so overflow is read from the sign bits.
module accum_sat_add #(
  parameter int W = conv_window_accum_pkg::DATA_WIDTH_DEF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
  assign sum = ovf ? (a[W-1] ? MIN_VAL : MAX_VAL) : raw;

endmodule

// File: rtl/conv_window_accum.sv
// Sums TERMS signed products plus a per-window bias with saturation and hands
// each window result to a one-entry, zero-bubble output buffer.
module conv_window_accum
  import conv_window_accum_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TERMS      = 9,
  parameter int CNT_WIDTH  = $clog2(TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  conv_window_accum_if.slave   bus
);

  state_t                       state_reg, state_next;
  logic signed [DATA_WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_WIDTH-1:0]         cnt_reg, cnt_next;
  logic                         sat_reg, sat_next;

  logic                         out_valid_reg;
  logic signed [DATA_WIDTH-1:0] out_data_reg;
  logic                         out_sat_reg;

  logic signed [DATA_WIDTH-1:0] op_a, sum;
  logic                         ovf;
  logic                         last_beat, accept, complete, win_flag;

  // cnt is 0 whenever the FSM is in IDLE, so this also covers TERMS == 1.
  assign last_beat = (cnt_reg == CNT_WIDTH'(TERMS - 1));
  assign bus.in_ready = !(last_beat && out_valid_reg && !bus.out_ready);
  assign accept    = bus.in_valid && bus.in_ready && !clear;
  assign complete  = accept && last_beat;

  assign op_a     = (state_reg == IDLE) ? bus.bias : acc_reg;
  assign win_flag = ((state_reg == IDLE) ? 1'b0 : sat_reg) | ovf;

  accum_sat_add #(.W(DATA_WIDTH)) u_add (
    .a   (op_a),
    .b   (bus.in_data),
    .sum (sum),
    .ovf (ovf)
  );

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    sat_next   = sat_reg;
    if (clear) begin
      state_next = IDLE;
      acc_next   = '0;
      cnt_next   = '0;
      sat_next   = 1'b0;
    end else if (accept) begin
      acc_next = sum;
      sat_next = win_flag;
      if (last_beat) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        state_next = ACCUM;
        cnt_next   = cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      sat_reg   <= sat_next;
    end
  end

  // A completion wins over a drain so a result can be replaced without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
    end else if (complete) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= sum;
      out_sat_reg   <= win_flag;
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sat   = out_sat_reg;

endmodule

// File: tb/tb_conv_window_accum.sv
// Directed bench for conv_window_accum: integer-arithmetic reference model,
// per-cycle comparison, plus literal expectations for each scenario.
module tb_conv_window_accum;
  import conv_window_accum_pkg::*;

  localparam int W     = 17;
  localparam int TERMS = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  conv_window_accum_if #(.DW(W)) bus ();

  conv_window_accum #(.DATA_WIDTH(W), .TERMS(TERMS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (plain integers) ----------------
  int m_pos, m_acc, m_flag;
  int m_ov, m_od, m_os;

  function automatic int clamp_add(input int a, input int b, output int o);
    int s;
    s = a + b;
    o = 0;
    if (s > int'(SAT_MAX)) begin s = int'(SAT_MAX); o = 1; end
    if (s < int'(SAT_MIN)) begin s = int'(SAT_MIN); o = 1; end
    return s;
  endfunction

  function automatic int model_ready();
    return ((m_pos == TERMS - 1) && m_ov != 0 && !bus.out_ready) ? 0 : 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int s, o, f, base;
    bit took, fin;
    if (!rst_n) begin
      m_pos <= 0; m_acc <= 0; m_flag <= 0;
      m_ov <= 0; m_od <= 0; m_os <= 0;
    end else begin
      took = bus.in_valid && (model_ready() != 0) && !clear;
      fin  = took && (m_pos == TERMS - 1);
      if (clear) begin
        m_pos <= 0; m_acc <= 0; m_flag <= 0;
      end else if (took) begin
        base = (m_pos == 0) ? int'(bus.bias) : m_acc;
        s = clamp_add(base, int'(bus.in_data), o);
        f = ((m_pos == 0) ? 0 : m_flag) | o;
        m_acc  <= s;
        m_flag <= f;
        m_pos  <= fin ? 0 : m_pos + 1;
        if (fin) begin
          m_ov <= 1; m_od <= s; m_os <= f;
        end
      end
      if (!fin && m_ov != 0 && bus.out_ready) m_ov <= 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", int'(bus.in_ready), model_ready());
      chk("out_valid", int'(bus.out_valid), m_ov);
      if (m_ov != 0) begin
        chk("out_data", int'(bus.out_data), m_od);
        chk("out_sat", int'(bus.out_sat), m_os);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int b, input int d);
    bit ok;
    bus.in_valid = 1'b1;
    bus.bias     = W'(b);
    bus.in_data  = W'(d);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        $display("beat bias=%0d data=%0d accepted", b, d);
        return;
      end
    end
    chk("beat_timeout", 0, 1);
  endtask

  task automatic expect_result(input string name, input int d, input int s);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, int'(bus.out_valid), 1);
    chk({name, "_data"}, int'(bus.out_data), d);
    chk({name, "_sat"}, int'(bus.out_sat), s);
    $display("window %s: out_data=%0d out_sat=%0d", name, bus.out_data, bus.out_sat);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.bias      = '0;
    bus.out_ready = 1'b1;

    // reset state
    #12;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // nominal: 10 + 1..9 = 55
    for (int i = 1; i <= 9; i++) send(10, i);
    expect_result("nominal", 55, 0);
    idle(2);

    // positive saturation: 65000+600 clamps, +100 clamps, -50 -> 65485
    send(65000, 600); send(65000, 100); send(65000, -50);
    for (int i = 0; i < 6; i++) send(65000, 0);
    expect_result("pos_sat", 65485, 1);
    idle(1);

    // negative saturation, then a clean window to show the flag does not leak
    for (int i = 0; i < 9; i++) send(-65536, -1);
    expect_result("neg_sat", -65536, 1);
    idle(1);
    for (int i = 0; i < 9; i++) send(0, 0);
    expect_result("zero_win", 0, 0);
    idle(1);

    // backpressure: window A = 45 held, window B = 100 + 9*2 = 118
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(0, i);
    for (int i = 0; i < 8; i++) send(100, 2);
    bus.in_valid = 1'b1;
    bus.in_data  = W'(2);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", int'(bus.in_ready), 0);
      chk("bp_hold_data", int'(bus.out_data), 45);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_high", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    expect_result("bp_second", 118, 0);
    idle(1);

    // clear mid-window with a buffered result (bias 5, zeros -> 5)
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(5, 0);
    for (int i = 0; i < 4; i++) send(0, 100);
    bus.in_valid = 1'b1;
    bus.in_data  = W'(100);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_buf_valid", int'(bus.out_valid), 1);
    chk("clr_buf_data", int'(bus.out_data), 5);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) send(0, 1);
    expect_result("after_clear", 9, 0);
    idle(1);

    // asynchronous reset while a result is buffered and the 9th beat is stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(0, 3);
    for (int i = 0; i < 8; i++) send(0, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = W'(1);
    @(negedge clk);
    chk("pre_rst_in_ready", int'(bus.in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", int'(bus.out_valid), 0);
    chk("async_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 9; i++) send(7, i);
    expect_result("post_reset", 52, 0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_window_accum.md
Name: conv_window_accum

Overview:
- Sequential accumulation stage that sits directly upstream of the convolution output path.
- Consumes a stream of signed partial products from the multiplier array.
- Sums exactly TERMS products per output, plus a per-window bias, using saturating two's-complement addition.
- Emits one saturated sum per window through a one-entry output buffer with a valid/ready handshake.

Parameters:
DATA_WIDTH, 17, width of products, bias, accumulator and result (signed two's complement)
TERMS, 9, number of products per window (3x3 kernel); legal range 1..1024
CNT_WIDTH, $clog2(TERMS+1), width of the term counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort: discards the partial window; output buffer is untouched
bias  input  DATA_WIDTH  signed bias, sampled on the first accepted beat of each window
in_valid  input  1  product beat valid
in_ready  output  1  block can accept a beat this cycle
in_data  input  DATA_WIDTH  signed product
out_valid  output  1  result buffer holds a result
out_ready  input  1  downstream accepts the result
out_data  output  DATA_WIDTH  signed window sum
out_sat  output  1  at least one saturation event occurred in this window

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, acc=0, cnt=0, sat_flag=0, out_valid=0, out_data=0, out_sat=0.
- Saturating add sat(a,b):
  - s = a+b truncated to DATA_WIDTH.
  - Overflow when sign(a)==sign(b) and sign(s)!=sign(a).
  - On overflow the result clamps to 2^(DATA_WIDTH-1)-1 if a is non-negative, or -2^(DATA_WIDTH-1) if a is negative.
  - No intermediate widening. Saturation applies at every step, so the sum is order-dependent by design.
- States: IDLE, ACCUM.
  - IDLE:
    - in_ready=1.
    - On a handshake (in_valid&in_ready): acc=sat(bias,in_data), sat_flag=that step's overflow, cnt=1.
    - If TERMS==1, complete the window (see below) and stay in IDLE; else go to ACCUM.
  - ACCUM:
    - On a handshake: acc=sat(acc,in_data), sat_flag |= overflow, cnt++.
    - When the beat accepted brings cnt to TERMS, the window completes: out_data<=the final sum, out_sat<=the final flag, out_valid<=1, cnt=0, state goes to IDLE.
- Backpressure:
  - in_ready=0 only when the next accepted beat would complete a window while out_valid=1 and out_ready=0.
  - in_ready = !(last_beat && out_valid && !out_ready). This is combinational from out_ready, which is intentional.
  - Non-final beats are never stalled.
- Output buffer:
  - On an out handshake with no simultaneous completion, out_valid<=0.
  - On a simultaneous out handshake and completion, the new result loads and out_valid stays 1 (zero-bubble).
  - out_data and out_sat are stable while out_valid=1 and out_ready=0.
- Latency: the result is visible the cycle after the final beat is accepted. Full throughput is one beat per cycle, so one result per TERMS cycles.
- clear:
  - Forces state=IDLE, cnt=0, sat_flag=0, acc=0 and masks any beat in that cycle; in_ready stays as computed, but the beat is dropped.
  - It does not alter out_valid, out_data or out_sat.
- Reset mid-window: the partial sum and any buffered result are lost.
- in_data and bias are ignored when in_valid=0. Bias is ignored on non-first beats.

Decomposition:
- Shared package holds:
  - the DATA_WIDTH default;
  - localparams SAT_MAX and SAT_MIN derived from it;
  - state encoding enum {IDLE, ACCUM}.
- One natural combinational sub-module: accum_sat_add (inputs a, b; outputs sum, ovf), implementing the sat rule above. It is instantiated once with a mux selecting bias or acc as operand a.
- Counter, FSM and output buffer stay in the top module.

Test Plan:
- Nominal window: bias=10, nine beats in_data=1..9, out_ready=1 -> exactly one cycle after the ninth beat, out_valid=1, out_data=55, out_sat=0; in_ready stays high throughout.
- Positive saturation: bias=65000, beats 600,100,-50, then six zeros -> clamps to 65535 on beat 1; final out_data=65535+100... saturated path yields 65485 after -50; out_sat=1.
- Negative saturation: bias=-65536, nine beats of -1 -> out_data=-65536, out_sat=1. Next window of nine zeros with bias=0 -> out_data=0, out_sat=0, so the flag does not leak between windows.
- Backpressure: hold out_ready=0 across two full windows -> first result holds stable; in_ready drops only on the 9th beat of window two. Raise out_ready -> first result consumed, 9th beat accepted the same cycle, second result appears the next cycle with no loss.
- clear mid-window: accept 4 beats of 100, assert clear while in_valid=1, then run a nine-beat window of 1 with bias=0 -> out_data=9; the buffered prior result is unaffected.
- Async reset: drop rst_n mid-window while out_valid=1 -> out_valid=0 and in_ready=1 immediately (no clock edge needed); the next window computes from a clean state.
